// File: rtl/npu_pkg.sv
// Shared sizing and controller state encoding for the
// line-feature detector.
package npu_pkg;

    localparam int DATA_W  = 8;
    localparam int NUM_PIX = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        SCAN    = 2'd2,
        DONE    = 2'd3
    } ctrl_state_t;

endpackage

// File: rtl/median3.sv
// Combinational middle-of-three selector for unsigned values.
// Ties resolve to the shared value.
module median3 #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    output logic [W-1:0] med
);

    logic [W-1:0] lo_ab;
    logic [W-1:0] hi_ab;
    logic [W-1:0] hi_c;

    always_comb begin
        lo_ab = (a < b) ? a : b;
        hi_ab = (a < b) ? b : a;
        hi_c  = (hi_ab < c) ? hi_ab : c;
        med   = (lo_ab > hi_c) ? lo_ab : hi_c;
    end

endmodule

// File: rtl/top_controller.sv
// Frame-level line-feature detector: collects one line, sweeps a
// 3-tap median window across it, reports peak and contrast.
module top_controller
    import npu_pkg::*;
#(
    parameter int NUM_PIX_P = NUM_PIX,
    parameter int DATA_W_P  = DATA_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [DATA_W_P-1:0] rx_data,
    input  logic                rx_valid,
    output logic [DATA_W_P-1:0] tx_data,
    output logic                done_signal,
    output logic [DATA_W_P-1:0] confidence
);

    localparam int IDX_W = $clog2(NUM_PIX_P);
    localparam logic [IDX_W-1:0] LAST_PIX = IDX_W'(NUM_PIX_P - 1);
    localparam logic [IDX_W-1:0] LAST_WIN = IDX_W'(NUM_PIX_P - 3);

    ctrl_state_t         state;
    logic [DATA_W_P-1:0] pix_buf [NUM_PIX_P];
    logic [IDX_W-1:0]    wr_idx;
    logic [IDX_W-1:0]    win_idx;
    logic [DATA_W_P-1:0] peak_q;
    logic [DATA_W_P-1:0] min_q;

    logic [IDX_W-1:0]    win_idx1;
    logic [IDX_W-1:0]    win_idx2;
    logic [DATA_W_P-1:0] med;
    logic [DATA_W_P-1:0] peak_nxt;
    logic [DATA_W_P-1:0] min_nxt;

    always_comb begin
        win_idx1 = win_idx + IDX_W'(1);
        win_idx2 = win_idx + IDX_W'(2);
    end

    median3 #(.W(DATA_W_P)) u_med (
        .a  (pix_buf[win_idx]),
        .b  (pix_buf[win_idx1]),
        .c  (pix_buf[win_idx2]),
        .med(med)
    );

    always_comb begin
        peak_nxt = (med > peak_q) ? med : peak_q;
        min_nxt  = (med < min_q)  ? med : min_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            wr_idx      <= '0;
            win_idx     <= '0;
            peak_q      <= '0;
            min_q       <= '0;
            tx_data     <= '0;
            confidence  <= '0;
            done_signal <= 1'b0;
            for (int i = 0; i < NUM_PIX_P; i++) begin
                pix_buf[i] <= '0;
            end
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state       <= COLLECT;
                        wr_idx      <= '0;
                        done_signal <= 1'b0;
                    end
                end
                COLLECT: begin
                    if (rx_valid) begin
                        pix_buf[wr_idx] <= rx_data;
                        wr_idx          <= wr_idx + IDX_W'(1);
                        if (wr_idx == LAST_PIX) begin
                            state   <= SCAN;
                            win_idx <= '0;
                            peak_q  <= '0;
                            min_q   <= '1;
                        end
                    end
                end
                SCAN: begin
                    peak_q  <= peak_nxt;
                    min_q   <= min_nxt;
                    win_idx <= win_idx1;
                    // Last window: publish from the updated trackers directly
                    if (win_idx == LAST_WIN) begin
                        state       <= DONE;
                        tx_data     <= peak_nxt;
                        confidence  <= peak_nxt - min_nxt;
                        done_signal <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_top_controller.sv
// Directed self-checking bench for top_controller.
`timescale 1ns/1ps
module tb_top_controller;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       done_signal;
    logic [7:0] confidence;

    int pass_cnt;
    int total_cnt;
    logic [7:0] pix [32];

    top_controller dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .tx_data    (tx_data),
        .done_signal(done_signal),
        .confidence (confidence)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic load_pix(input int kind);
        for (int i = 0; i < 32; i++) begin
            case (kind)
                0: pix[i] = 8'd0;
                1: pix[i] = 8'h80;
                default: pix[i] = 8'(i * 8);
            endcase
        end
        if (kind == 0) begin
            pix[15] = 8'd100;
            pix[16] = 8'd200;
            pix[17] = 8'd250;
        end
    endtask

    // Start pulse carries a junk byte that must not be taken as pixel 0
    task automatic do_start();
        @(negedge clk);
        start    = 1'b1;
        rx_valid = 1'b1;
        rx_data  = 8'hEE;
        @(negedge clk);
        start    = 1'b0;
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input bit gaps, input bit junk,
                              output int lat);
        for (int i = 0; i < 32; i++) begin
            if (gaps && (i % 3 == 1)) begin
                rx_valid = 1'b0;
                rx_data  = 8'h55;
                @(negedge clk);
            end
            rx_valid = 1'b1;
            rx_data  = pix[i];
            start    = gaps && (i == 10);
            if (i == 31) begin
                @(posedge clk);
                #1;
            end else begin
                @(negedge clk);
            end
        end
        start    = 1'b0;
        rx_valid = junk;
        rx_data  = 8'hFF;
        lat = -1;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk);
            #1;
            if (done_signal) begin
                lat = n;
                break;
            end
        end
        rx_valid = 1'b0;
    endtask

    task automatic check_result(input string name, input int lat,
                                input logic [7:0] exp_tx,
                                input logic [7:0] exp_conf,
                                input bit chk_lat);
        if (chk_lat) begin
            total_cnt++;
            if (lat !== 30)
                $display("FAIL %s latency got=%0d exp=30", name, lat);
            else pass_cnt++;
        end
        total_cnt++;
        if (tx_data !== exp_tx)
            $display("FAIL %s tx_data got=%0d exp=%0d", name, tx_data, exp_tx);
        else pass_cnt++;
        total_cnt++;
        if (confidence !== exp_conf)
            $display("FAIL %s confidence got=%0d exp=%0d",
                     name, confidence, exp_conf);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        start = 1'b0;
        rx_valid = 1'b0;
        rx_data = 8'h00;
        repeat (3) @(negedge clk);
        total_cnt++;
        if (done_signal !== 1'b0)
            $display("FAIL reset done got=%b exp=0", done_signal);
        else pass_cnt++;
        check_result("reset", 30, 8'd0, 8'd0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_impulse();
        int lat;
        load_pix(0);
        do_start();
        send_frame(1'b0, 1'b0, lat);
        check_result("impulse", lat, 8'd200, 8'd200, 1'b1);
        repeat (5) @(negedge clk);
        total_cnt++;
        if (done_signal !== 1'b1 || tx_data !== 8'd200)
            $display("FAIL sticky done=%b tx=%0d exp done=1 tx=200",
                     done_signal, tx_data);
        else pass_cnt++;
    endtask

    task automatic test_flat();
        int lat;
        load_pix(1);
        do_start();
        send_frame(1'b0, 1'b0, lat);
        check_result("flat", lat, 8'd128, 8'd0, 1'b1);
    endtask

    task automatic test_ramp();
        int lat;
        load_pix(2);
        do_start();
        send_frame(1'b0, 1'b0, lat);
        check_result("ramp", lat, 8'd240, 8'd232, 1'b1);
    endtask

    task automatic test_gaps();
        int lat;
        load_pix(0);
        do_start();
        send_frame(1'b1, 1'b1, lat);
        check_result("gaps", lat, 8'd200, 8'd200, 1'b0);
    endtask

    task automatic test_back_to_back();
        int lat;
        load_pix(2);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        total_cnt++;
        if (done_signal !== 1'b0 || tx_data !== 8'd200)
            $display("FAIL b2b_drop done=%b tx=%0d exp done=0 tx=200",
                     done_signal, tx_data);
        else pass_cnt++;
        send_frame(1'b0, 1'b0, lat);
        check_result("b2b", lat, 8'd240, 8'd232, 1'b1);
    endtask

    task automatic test_reset_mid_scan();
        int lat;
        load_pix(0);
        do_start();
        for (int i = 0; i < 32; i++) begin
            rx_valid = 1'b1;
            rx_data  = pix[i];
            @(negedge clk);
        end
        rx_valid = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b0;
        #1;
        total_cnt++;
        if (done_signal !== 1'b0)
            $display("FAIL midreset done got=%b exp=0", done_signal);
        else pass_cnt++;
        check_result("midreset", 30, 8'd0, 8'd0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        load_pix(1);
        do_start();
        send_frame(1'b0, 1'b0, lat);
        check_result("after_reset", lat, 8'd128, 8'd0, 1'b1);
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        test_reset();
        test_impulse();
        test_flat();
        test_ramp();
        test_gaps();
        test_back_to_back();
        test_reset_mid_scan();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
